// File: rtl/xor_stream_cipher.sv
// Serial XOR stream cipher: serial key load, then per-bit encryption with a rotating or Galois-LFSR keystream.
// Valid/ready contract: no back-pressure; a bit is accepted on every ena cycle in STREAM with iMsg_flag=1, and oData_flag marks oData_out valid for exactly that one following cycle.
`timescale 1ns/1ps
module xor_stream_cipher #(
  parameter int                  MSG_SIZE  = 128,
  parameter int                  KEY_SIZE  = 8,
  parameter logic [KEY_SIZE-1:0] LFSR_TAPS = 8'hB8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ena,
  input  logic                        iData_in,
  input  logic                        iKey_flag,
  input  logic                        iMsg_flag,
  input  logic                        iMode,
  output logic                        oData_out,
  output logic                        oData_flag,
  output logic                        oKey_ready,
  output logic                        oBusy,
  output logic                        oDone,
  output logic                        oOverflow,
  output logic [$clog2(MSG_SIZE):0]   oBit_counter,
  output logic [2:0]                  oState_dbg
);

  localparam int CW  = $clog2(MSG_SIZE) + 1;
  localparam int KCW = $clog2(KEY_SIZE) + 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_KEY = 3'd1,
    S_READY    = 3'd2,
    S_STREAM   = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [KEY_SIZE-1:0]   key_q, key_d;
  logic [KCW-1:0]        kcnt_q, kcnt_d;
  logic [KEY_SIZE-1:0]   w_q, w_d;
  logic                  mode_q, mode_d;
  logic                  msg_prev_q;
  logic                  data_out_q, data_out_d;
  logic                  data_flag_q, data_flag_d;
  logic                  key_ready_q, key_ready_d;
  logic                  ovf_q, ovf_d;
  logic [CW-1:0]         bcnt_q, bcnt_d;

  // Advance the working key by one keystream bit.
  function automatic logic [KEY_SIZE-1:0] step_w(input logic [KEY_SIZE-1:0] w,
                                                 input logic                mode);
    logic [KEY_SIZE-1:0] sh;
    sh = {w[KEY_SIZE-2:0], 1'b0};
    if (mode) step_w = sh ^ (w[KEY_SIZE-1] ? LFSR_TAPS : '0);
    else      step_w = {w[KEY_SIZE-2:0], w[KEY_SIZE-1]};
  endfunction

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    kcnt_d      = kcnt_q;
    w_d         = w_q;
    mode_d      = mode_q;
    data_out_d  = data_out_q;
    data_flag_d = 1'b0;
    key_ready_d = key_ready_q;
    ovf_d       = ovf_q;
    bcnt_d      = bcnt_q;

    case (state_q)
      S_IDLE, S_READY: begin
        if (iKey_flag) begin
          state_d     = S_LOAD_KEY;
          key_ready_d = 1'b0;
          kcnt_d      = KCW'(1);
          key_d       = {key_q[KEY_SIZE-2:0], iData_in};
        end else if (state_q == S_READY && iMsg_flag && !msg_prev_q) begin
          // First bit is taken on the start edge straight from the loaded key.
          state_d     = S_STREAM;
          mode_d      = iMode;
          ovf_d       = 1'b0;
          bcnt_d      = CW'(1);
          data_out_d  = iData_in ^ key_q[KEY_SIZE-1];
          data_flag_d = 1'b1;
          w_d         = step_w(key_q, iMode);
        end
      end
      S_LOAD_KEY: begin
        if (iKey_flag) begin
          key_d = {key_q[KEY_SIZE-2:0], iData_in};
          if (kcnt_q != KCW'(KEY_SIZE)) kcnt_d = kcnt_q + KCW'(1);
        end else if (kcnt_q == KCW'(KEY_SIZE)) begin
          state_d     = S_READY;
          key_ready_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STREAM: begin
        if (bcnt_q == CW'(MSG_SIZE)) begin
          state_d = S_DONE;
          if (iMsg_flag) ovf_d = 1'b1;
        end else if (!iMsg_flag) begin
          state_d = S_DONE;
        end else begin
          data_out_d  = iData_in ^ w_q[KEY_SIZE-1];
          data_flag_d = 1'b1;
          bcnt_d      = bcnt_q + CW'(1);
          w_d         = step_w(w_q, mode_q);
        end
      end
      S_DONE:  state_d = S_READY;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      key_q       <= '0;
      kcnt_q      <= '0;
      w_q         <= '0;
      mode_q      <= 1'b0;
      msg_prev_q  <= 1'b0;
      data_out_q  <= 1'b0;
      data_flag_q <= 1'b0;
      key_ready_q <= 1'b0;
      ovf_q       <= 1'b0;
      bcnt_q      <= '0;
    end else if (ena) begin
      state_q     <= state_d;
      key_q       <= key_d;
      kcnt_q      <= kcnt_d;
      w_q         <= w_d;
      mode_q      <= mode_d;
      msg_prev_q  <= iMsg_flag;
      data_out_q  <= data_out_d;
      data_flag_q <= data_flag_d;
      key_ready_q <= key_ready_d;
      ovf_q       <= ovf_d;
      bcnt_q      <= bcnt_d;
    end
  end

  assign oData_out    = data_out_q;
  assign oData_flag   = data_flag_q;
  assign oKey_ready   = key_ready_q;
  assign oBusy        = (state_q == S_STREAM);
  assign oDone        = (state_q == S_DONE);
  assign oOverflow    = ovf_q;
  assign oBit_counter = bcnt_q;
  assign oState_dbg   = state_q;

endmodule
